// File: rtl/et_trig_decision_pkg.sv
// Shared types and helpers for the ET trigger decision block.
// State encoding, ET word fields and a saturating counter increment.
package et_trig_decision_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DEAD = 1'b1
  } state_e;

  localparam int IS_ET_BIT = 16;
  localparam int ET_MSB    = 15;
  localparam int VETO_W    = 32;

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] max,
    input logic        en
  );
    return (en && v != max) ? v + 64'd1 : v;
  endfunction

endpackage

// File: rtl/et_trig_decision_prescaler.sv
// Prescale counter: fires on every eff_ps-th clean tick.
// Compare uses >= so a lowered prescale fires on the next tick.
module trig_prescaler #(
  parameter int PS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            tick,
  input  logic [PS_W-1:0] prescale,
  output logic            fire
);

  logic [PS_W-1:0] r_ps_cnt;
  logic [PS_W-1:0] w_eff;
  logic [PS_W-1:0] w_cnt;

  assign w_eff = (prescale == '0) ? PS_W'(1) : prescale;
  assign w_cnt = clr ? '0 : r_ps_cnt;
  assign fire  = tick & (w_cnt >= w_eff - PS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps_cnt <= '0;
    end else if (fire) begin
      r_ps_cnt <= '0;
    end else if (tick) begin
      r_ps_cnt <= w_cnt + PS_W'(1);
    end else if (clr) begin
      r_ps_cnt <= '0;
    end
  end

endmodule

// File: rtl/et_trig_decision.sv
// Physics trigger decision: ET threshold, veto mask, prescale, dead time.
// Registered trigger pulse, last-accept record and per-spill counters.
module et_trig_decision
  import et_trig_decision_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DEAD_W = 8,
  parameter int PS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_spill,
  input  logic              in_ena_trig,
  input  logic              in_ena_delta,
  input  logic [16:0]       in_et,
  input  logic [VETO_W-1:0] in_veto,
  input  logic [31:0]       timestamp,
  input  logic [15:0]       et_thre,
  input  logic [VETO_W-1:0] veto_mask,
  input  logic [PS_W-1:0]   prescale,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              out_trig,
  output logic [31:0]       out_trig_ts,
  output logic [15:0]       out_trig_et,
  output logic [CNT_W-1:0]  cnt_raw,
  output logic [CNT_W-1:0]  cnt_vetoed,
  output logic [CNT_W-1:0]  cnt_dead,
  output logic [CNT_W-1:0]  cnt_accept,
  output logic              busy
);

  localparam logic [63:0] CMAX = 64'({CNT_W{1'b1}});

  state_e            r_state;
  logic [DEAD_W-1:0] r_dead;
  logic              r_spill;
  logic              r_trig;
  logic              r_busy;
  logic [31:0]       r_ts;
  logic [15:0]       r_et;
  logic [CNT_W-1:0]  r_raw;
  logic [CNT_W-1:0]  r_vet;
  logic [CNT_W-1:0]  r_dcnt;
  logic [CNT_W-1:0]  r_acc;

  logic w_gate;
  logic w_cand;
  logic w_vet;
  logic w_clean;
  logic w_rise;
  logic w_idle;
  logic w_tick;
  logic w_fire;
  logic w_lost;

  assign w_gate  = in_spill & in_ena_trig & ~in_ena_delta;
  assign w_cand  = w_gate & in_et[IS_ET_BIT] &
                   (in_et[ET_MSB:0] > et_thre);
  assign w_vet   = |(in_veto & veto_mask);
  assign w_clean = w_cand & ~w_vet;
  assign w_rise  = in_spill & ~r_spill;
  // a spill start forces IDLE, so the edge cycle may accept
  assign w_idle  = (r_state == IDLE) | w_rise;
  assign w_tick  = w_clean & w_idle;
  assign w_lost  = w_clean & ~w_idle;

  trig_prescaler #(
    .PS_W(PS_W)
  ) u_ps (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_rise),
    .tick    (w_tick),
    .prescale(prescale),
    .fire    (w_fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dead  <= '0;
      r_spill <= 1'b0;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_ts    <= '0;
      r_et    <= '0;
    end else begin
      r_spill <= in_spill;
      r_trig  <= w_fire;
      if (w_fire) begin
        r_ts <= timestamp;
        r_et <= in_et[ET_MSB:0];
      end else if (w_rise) begin
        r_ts <= '0;
        r_et <= '0;
      end
      if (w_fire && dead_time != '0) begin
        r_state <= DEAD;
        r_busy  <= 1'b1;
        r_dead  <= dead_time;
      end else if (w_rise) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_dead  <= '0;
      end else if (r_state == DEAD) begin
        r_dead <= r_dead - DEAD_W'(1);
        if (r_dead == DEAD_W'(1)) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw  <= '0;
      r_vet  <= '0;
      r_dcnt <= '0;
      r_acc  <= '0;
    end else begin
      r_raw  <= CNT_W'(sat_inc(w_rise ? '0 : 64'(r_raw),
                               CMAX, w_cand));
      r_vet  <= CNT_W'(sat_inc(w_rise ? '0 : 64'(r_vet),
                               CMAX, w_cand & w_vet));
      r_dcnt <= CNT_W'(sat_inc(w_rise ? '0 : 64'(r_dcnt),
                               CMAX, w_lost));
      r_acc  <= CNT_W'(sat_inc(w_rise ? '0 : 64'(r_acc),
                               CMAX, w_fire));
    end
  end

  assign out_trig    = r_trig;
  assign out_trig_ts = r_ts;
  assign out_trig_et = r_et;
  assign cnt_raw     = r_raw;
  assign cnt_vetoed  = r_vet;
  assign cnt_dead    = r_dcnt;
  assign cnt_accept  = r_acc;
  assign busy        = r_busy;

endmodule

// File: tb/tb_et_trig_decision.sv
// Directed bench for et_trig_decision.
// Trigger pulses are matched against a queue of expected records.
module tb_et_trig_decision;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_spill = 1'b0;
  logic        in_ena_trig = 1'b0;
  logic        in_ena_delta = 1'b0;
  logic [16:0] in_et = '0;
  logic [31:0] in_veto = '0;
  logic [31:0] timestamp = '0;
  logic [15:0] et_thre = '0;
  logic [31:0] veto_mask = '0;
  logic [15:0] prescale = '0;
  logic [7:0]  dead_time = '0;

  logic        out_trig;
  logic [31:0] out_trig_ts;
  logic [15:0] out_trig_et;
  logic [31:0] cnt_raw, cnt_vetoed, cnt_dead, cnt_accept;
  logic        busy;

  logic        s_trig;
  logic [31:0] s_ts;
  logic [15:0] s_et;
  logic [1:0]  s_raw, s_vet, s_dead, s_acc;
  logic        s_busy;

  et_trig_decision dut (
    .clk(clk), .rst(rst), .in_spill(in_spill),
    .in_ena_trig(in_ena_trig), .in_ena_delta(in_ena_delta),
    .in_et(in_et), .in_veto(in_veto), .timestamp(timestamp),
    .et_thre(et_thre), .veto_mask(veto_mask),
    .prescale(prescale), .dead_time(dead_time),
    .out_trig(out_trig), .out_trig_ts(out_trig_ts),
    .out_trig_et(out_trig_et), .cnt_raw(cnt_raw),
    .cnt_vetoed(cnt_vetoed), .cnt_dead(cnt_dead),
    .cnt_accept(cnt_accept), .busy(busy)
  );

  et_trig_decision #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_spill(in_spill),
    .in_ena_trig(in_ena_trig), .in_ena_delta(in_ena_delta),
    .in_et(in_et), .in_veto(in_veto), .timestamp(timestamp),
    .et_thre(et_thre), .veto_mask(veto_mask),
    .prescale(prescale), .dead_time(dead_time),
    .out_trig(s_trig), .out_trig_ts(s_ts),
    .out_trig_et(s_et), .cnt_raw(s_raw),
    .cnt_vetoed(s_vet), .cnt_dead(s_dead),
    .cnt_accept(s_acc), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int bcnt = 0;
  logic [31:0] tsv = 32'd1000;
  logic [47:0] q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // scoreboard monitor: every trigger pulse consumes one record
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) bcnt++;
      if (out_trig) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL trig_unexpected: got ts=%0h et=%0h expected none",
                   out_trig_ts, out_trig_et);
        end else begin
          logic [47:0] e;
          e = q.pop_front();
          if ({out_trig_ts, out_trig_et} === e) n_pass++;
          else $display("FAIL trig_record: got %0h expected %0h",
                        {out_trig_ts, out_trig_et}, e);
        end
      end
    end
  end

  task automatic cyc(input logic is, input logic [15:0] e,
                     input bit acc);
    in_et = {is, e};
    timestamp = tsv;
    if (acc) q.push_back({tsv, e});
    tsv++;
    @(posedge clk);
    #1;
  endtask

  task automatic new_spill();
    in_spill = 1'b0;
    cyc(1'b0, 16'd0, 1'b0);
    in_spill = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_trig", 64'(out_trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_raw", 64'(cnt_raw), 64'd0);
    chk("rst_ts", 64'(out_trig_ts), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    et_thre = 16'd100;
    prescale = 16'd1;
    dead_time = 8'd0;
    in_ena_trig = 1'b1;
    in_spill = 1'b1;

    // threshold, back-to-back accepts
    repeat (3) cyc(1'b1, 16'd101, 1'b1);
    cyc(1'b1, 16'd100, 1'b0);
    cyc(1'b0, 16'd200, 1'b0);
    chk("t1_accept", 64'(cnt_accept), 64'd3);
    chk("t1_raw", 64'(cnt_raw), 64'd3);
    chk("t1_et_hold", 64'(out_trig_et), 64'd101);

    // veto masking
    new_spill();
    veto_mask = 32'h0001_0000;
    in_veto = 32'h0001_0000;
    cyc(1'b1, 16'd120, 1'b0);
    chk("t2_raw", 64'(cnt_raw), 64'd1);
    chk("t2_vetoed", 64'(cnt_vetoed), 64'd1);
    veto_mask = 32'h0;
    cyc(1'b1, 16'd121, 1'b1);
    in_veto = 32'h0;
    cyc(1'b0, 16'd0, 1'b0);
    chk("t2_accept", 64'(cnt_accept), 64'd1);

    // prescale 4
    new_spill();
    prescale = 16'd4;
    for (int k = 1; k <= 10; k++)
      cyc(1'b1, 16'(200 + k), (k == 4 || k == 8));
    cyc(1'b0, 16'd0, 1'b0);
    chk("t3_accept", 64'(cnt_accept), 64'd2);
    chk("t3_raw", 64'(cnt_raw), 64'd10);

    // dead time 5
    new_spill();
    prescale = 16'd1;
    dead_time = 8'd5;
    bcnt = 0;
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 16'(300 + k), (k == 0));
    cyc(1'b0, 16'd0, 1'b0);
    chk("t4_busy_len", 64'(bcnt), 64'd5);
    chk("t4_dead", 64'(cnt_dead), 64'd5);
    cyc(1'b1, 16'd310, 1'b1);
    cyc(1'b0, 16'd0, 1'b0);
    chk("t4_accept", 64'(cnt_accept), 64'd2);
    chk("t4_raw", 64'(cnt_raw), 64'd7);

    // spill off freezes, spill on clears
    in_spill = 1'b0;
    cyc(1'b1, 16'd150, 1'b0);
    cyc(1'b1, 16'd150, 1'b0);
    chk("t5_hold_raw", 64'(cnt_raw), 64'd7);
    chk("t5_hold_acc", 64'(cnt_accept), 64'd2);
    in_spill = 1'b1;
    cyc(1'b0, 16'd0, 1'b0);
    chk("t5_clr_raw", 64'(cnt_raw), 64'd0);
    chk("t5_clr_acc", 64'(cnt_accept), 64'd0);
    chk("t5_clr_dead", 64'(cnt_dead), 64'd0);
    chk("t5_clr_ts", 64'(out_trig_ts), 64'd0);
    chk("t5_clr_et", 64'(out_trig_et), 64'd0);
    in_ena_delta = 1'b1;
    cyc(1'b1, 16'd150, 1'b0);
    in_ena_delta = 1'b0;
    chk("t5_delta_raw", 64'(cnt_raw), 64'd0);

    // lowered prescale fires on next clean candidate
    dead_time = 8'd0;
    prescale = 16'd4;
    cyc(1'b1, 16'd160, 1'b0);
    cyc(1'b1, 16'd161, 1'b0);
    prescale = 16'd2;
    cyc(1'b1, 16'd162, 1'b1);
    cyc(1'b0, 16'd0, 1'b0);
    chk("t6_accept", 64'(cnt_accept), 64'd1);
    chk("t6_raw", 64'(cnt_raw), 64'd3);

    // async reset mid-DEAD
    prescale = 16'd1;
    dead_time = 8'd10;
    cyc(1'b1, 16'd170, 1'b1);
    cyc(1'b0, 16'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0);
    chk("t7_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_acc", 64'(cnt_accept), 64'd0);
    chk("t7_ts", 64'(out_trig_ts), 64'd0);
    chk("t7_trig", 64'(out_trig), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // saturation on a narrow-counter instance
    dead_time = 8'd0;
    repeat (4) cyc(1'b1, 16'd180, 1'b1);
    cyc(1'b0, 16'd0, 1'b0);
    chk("t8_acc_main", 64'(cnt_accept), 64'd4);
    chk("t8_acc_sat", 64'(s_acc), 64'd3);
    chk("t8_raw_sat", 64'(s_raw), 64'd3);

    repeat (2) cyc(1'b0, 16'd0, 1'b0);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
